// File: rtl/cart_bus_arbiter.sv
// Arbitrates console cartridge reads against loader writes onto one memory port; optional timeout via CART_ARB_TIMEOUT_EN.
// Latency: console start to mem_req is 2 cycles; mem_ack to rd_valid/ld_ack is 1 cycle.
// Backpressure: mem_req is held until mem_ack; ld_req is held by the loader until ld_ack.
module cart_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 16
) (
    input  logic              MCLK,
    input  logic              SRES,
    input  logic              cs_n,
    input  logic              oe_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {S_IDLE, S_CART, S_LOAD, S_HOLD} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_strobe_q;
    logic              r_cart_pend;
    logic [ADDR_W-1:0] r_cart_addr;
    logic              r_abort;
    logic              w_strobe;
    logic              w_start;
    logic              w_keep;
    logic              w_tmo;

    assign w_strobe = ~(cs_n | oe_n);
    assign w_start  = w_strobe & ~r_strobe_q;
    assign w_keep   = w_strobe & ~r_abort;
    assign busy     = (r_state != S_IDLE);

`ifdef CART_ARB_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_err;

    // Fires on the edge where the counter would reach 255, so mem_req is high for exactly 255 cycles.
    assign w_tmo = ((r_state == S_CART) || (r_state == S_LOAD)) & mem_req & ~mem_ack
                   & (r_tmo_cnt == 8'd254);
    assign err   = r_err;

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            r_tmo_cnt <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_IDLE)
                r_tmo_cnt <= 8'd0;
            else if (mem_req && !mem_ack)
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            if (w_tmo)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end
`else
    logic w_unused_err_clr;

    assign w_tmo            = 1'b0;
    assign err              = 1'b0;
    assign w_unused_err_clr = err_clr;
`endif

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            // A start seen this cycle is not yet in cart_pend; holding off the loader lets CART win a tie.
            S_IDLE: begin
                if (r_cart_pend)
                    w_next = S_CART;
                else if (ld_req && !w_start)
                    w_next = S_LOAD;
            end
            S_CART: begin
                if (mem_ack)
                    w_next = w_keep ? S_HOLD : S_IDLE;
                else if (w_tmo)
                    w_next = S_HOLD;
            end
            S_LOAD: begin
                if (mem_ack || w_tmo)
                    w_next = S_IDLE;
            end
            S_HOLD: begin
                if (!w_strobe)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            r_strobe_q  <= 1'b0;
            r_cart_pend <= 1'b0;
            r_cart_addr <= '0;
            r_abort     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            ld_ack      <= 1'b0;
        end else begin
            r_strobe_q <= w_strobe;
            ld_ack     <= 1'b0;

            if (r_state == S_IDLE && r_cart_pend)
                r_cart_pend <= 1'b0;
            if (w_start) begin
                r_cart_addr <= addr;
                r_cart_pend <= 1'b1;
            end

            // Remembers a strobe drop anywhere in CART so a later re-strobe cannot revive stale data.
            if (r_state == S_IDLE)
                r_abort <= 1'b0;
            else if (r_state == S_CART && !w_strobe)
                r_abort <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_next == S_CART) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= r_cart_addr;
                    end else if (w_next == S_LOAD) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_data;
                    end
                end
                S_CART: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (w_keep) begin
                            rd_data  <= mem_rdata;
                            rd_valid <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        mem_req  <= 1'b0;
                        rd_data  <= '1;
                        rd_valid <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (mem_ack || w_tmo) begin
                        mem_req <= 1'b0;
                        ld_ack  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_strobe)
                        rd_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter: console reads, loader writes, tie-break, abort, reset, optional timeout.
module tb_cart_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;

    logic              MCLK = 1'b0;
    logic              SRES = 1'b0;
    logic              cs_n = 1'b1;
    logic              oe_n = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ld_req = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              busy;
    logic              err;
    logic              err_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    cart_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .MCLK     (MCLK),
        .SRES     (SRES),
        .cs_n     (cs_n),
        .oe_n     (oe_n),
        .addr     (addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_ack   (ld_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   mem_req,   0);
        chk({tag, "_mem_we"},    mem_we,    0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rd_data"},   rd_data,   0);
        chk({tag, "_rd_valid"},  rd_valid,  0);
        chk({tag, "_ld_ack"},    ld_ack,    0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_err"},       err,       0);
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk_reset_outputs("rst");
        SRES = 1'b1;
        cyc(2);
        chk("idle_busy", busy, 0);

        // Idle read at 0x01234, memory acks on the third cycle of mem_req
        cs_n = 1'b0; oe_n = 1'b0; addr = 21'h01234;
        cyc(1);
        chk("rd1_req_lat1", mem_req, 0);
        cyc(1);
        chk("rd1_req_lat2", mem_req, 1);
        chk("rd1_we", mem_we, 0);
        chk("rd1_addr", mem_addr, 32'h01234);
        chk("rd1_busy", busy, 1);
        cyc(2);
        chk("rd1_req_held", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        cyc(1);
        mem_ack = 1'b0;
        chk("rd1_req_drop", mem_req, 0);
        chk("rd1_valid", rd_valid, 1);
        chk("rd1_data", rd_data, 32'hBEEF);
        cyc(2);
        chk("rd1_valid_hold", rd_valid, 1);
        cs_n = 1'b1; oe_n = 1'b1;
        cyc(1);
        chk("rd1_valid_clr", rd_valid, 0);
        chk("rd1_data_keep", rd_data, 32'hBEEF);
        chk("rd1_idle", busy, 0);

        // Loader write 0x1FFFF <= 0x5A5A
        ld_req = 1'b1; ld_addr = 21'h1FFFF; ld_data = 16'h5A5A;
        cyc(1);
        chk("ld1_req", mem_req, 1);
        chk("ld1_we", mem_we, 1);
        chk("ld1_addr", mem_addr, 32'h1FFFF);
        chk("ld1_wdata", mem_wdata, 32'h5A5A);
        chk("ld1_ack_early", ld_ack, 0);
        mem_ack = 1'b1;
        cyc(1);
        mem_ack = 1'b0; ld_req = 1'b0;
        chk("ld1_ack", ld_ack, 1);
        chk("ld1_req_drop", mem_req, 0);
        cyc(1);
        chk("ld1_ack_pulse", ld_ack, 0);
        chk("ld1_busy", busy, 0);

        // Console start and ld_req together: CART first, then LOAD
        cs_n = 1'b0; oe_n = 1'b0; addr = 21'h00042;
        ld_req = 1'b1; ld_addr = 21'h00100; ld_data = 16'h1234;
        cyc(1);
        chk("tie_no_load", mem_req, 0);
        cyc(1);
        chk("tie_cart_we", mem_we, 0);
        chk("tie_cart_addr", mem_addr, 32'h00042);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        cyc(1);
        mem_ack = 1'b0;
        chk("tie_rd_valid", rd_valid, 1);
        chk("tie_rd_data", rd_data, 32'hCAFE);
        chk("tie_no_ldack", ld_ack, 0);
        cs_n = 1'b1; oe_n = 1'b1;
        cyc(1);
        chk("tie_hold_exit", rd_valid, 0);
        cyc(1);
        chk("tie_load_req", mem_req, 1);
        chk("tie_load_we", mem_we, 1);
        chk("tie_load_addr", mem_addr, 32'h00100);
        mem_ack = 1'b1;
        cyc(1);
        mem_ack = 1'b0; ld_req = 1'b0;
        chk("tie_ld_ack", ld_ack, 1);
        cyc(1);
        chk("tie_ld_ack_once", ld_ack, 0);
        chk("tie_idle", busy, 0);

        // Strobe dropped one cycle into CART, ack five cycles in: data discarded
        cs_n = 1'b0; oe_n = 1'b0; addr = 21'h00777;
        cyc(2);
        chk("ab_req", mem_req, 1);
        cs_n = 1'b1; oe_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("ab_no_valid", rd_valid, 0);
        end
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        cyc(1);
        mem_ack = 1'b0;
        chk("ab_valid", rd_valid, 0);
        chk("ab_data_keep", rd_data, 32'hCAFE);
        chk("ab_idle", busy, 0);
        chk("ab_req_drop", mem_req, 0);
        ld_req = 1'b1; ld_addr = 21'h00002; ld_data = 16'h0003;
        cyc(1);
        chk("ab_load_req", mem_req, 1);
        chk("ab_load_we", mem_we, 1);
        chk("ab_load_addr", mem_addr, 32'h00002);

        // Async reset in the middle of a LOAD, with an ack arriving around it
        cyc(1);
        #1 SRES = 1'b0; mem_ack = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        cyc(1);
        SRES = 1'b1; ld_req = 1'b0;
        cyc(1);
        mem_ack = 1'b0;
        chk("post_rst_ldack", ld_ack, 0);
        chk("post_rst_req", mem_req, 0);
        chk("post_rst_busy", busy, 0);

`ifdef CART_ARB_TIMEOUT_EN
        // Read with no ack: times out after 255 cycles of mem_req
        cs_n = 1'b0; oe_n = 1'b0; addr = 21'h00010;
        cyc(2);
        chk("to_req", mem_req, 1);
        cyc(254);
        chk("to_req_254", mem_req, 1);
        chk("to_err_early", err, 0);
        cyc(1);
        chk("to_req_drop", mem_req, 0);
        chk("to_err", err, 1);
        chk("to_rd_data", rd_data, 32'hFFFF);
        chk("to_rd_valid", rd_valid, 1);
        err_clr = 1'b1; cs_n = 1'b1; oe_n = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("to_err_clr", err, 0);
        chk("to_valid_clr", rd_valid, 0);
`else
        // Without the timeout, mem_req waits indefinitely and err stays low
        cs_n = 1'b0; oe_n = 1'b0; addr = 21'h00010;
        cyc(2);
        chk("nto_req", mem_req, 1);
        cyc(300);
        chk("nto_req_held", mem_req, 1);
        chk("nto_err", err, 0);
        chk("nto_valid", rd_valid, 0);
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        cyc(1);
        mem_ack = 1'b0;
        chk("nto_rd_data", rd_data, 32'h0F0F);
        cs_n = 1'b1; oe_n = 1'b1;
        cyc(1);
        chk("nto_idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
